// File: rtl/fetch_prefetch_q_if.sv
// Wishbone B4 classic instruction-bus bundle.
// master: fetch unit (cyc/stb/we/sel/adr out, dat/ack/err in); slave: memory.
interface fetch_prefetch_q_if #(
  parameter int unsigned XLEN = 32
);
  logic              cyc_o;
  logic              stb_o;
  logic              we_o;
  logic [XLEN/8-1:0] sel_o;
  logic [XLEN-1:0]   adr_o;
  logic [XLEN-1:0]   dat_i;
  logic              ack_i;
  logic              err_i;

  modport master (
    output cyc_o, stb_o, we_o, sel_o, adr_o,
    input  dat_i, ack_i, err_i
  );

  modport slave (
    input  cyc_o, stb_o, we_o, sel_o, adr_o,
    output dat_i, ack_i, err_i
  );
endinterface

// File: rtl/fetch_prefetch_q.sv
// Prefetching instruction fetch unit: Wishbone read master feeding a
// DEPTH-entry {ir,pc,fault} queue. Ports: clk, rst (async, active high),
// wb (Wishbone master), inst_* valid/ready head, jump/jump_target, busy.
module fetch_prefetch_q #(
  parameter int unsigned    XLEN     = 32,
  parameter int unsigned    DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  fetch_prefetch_q_if.master wb,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_ir,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_fault,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  output logic            busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] adr_q, adr_d;
  logic            halted_q, halted_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [AW-1:0]   wr_q, wr_d;

  logic [XLEN-1:0] ir_mem  [DEPTH];
  logic [XLEN-1:0] pc_mem  [DEPTH];
  logic            flt_mem [DEPTH];

  logic            resp;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] push_ir;
  logic [CW-1:0]   cnt_nxt;
  logic            room;
  logic [XLEN-1:0] tgt;

  assign resp    = wb.ack_i | wb.err_i;
  assign tgt     = jump_target & ~XLEN'(3);

  // A response in the jump cycle belongs to the old stream.
  assign push    = (state_q == REQ) && resp && !jump;
  assign pop     = inst_valid && inst_ready && !jump;
  assign push_ir = wb.err_i ? '0 : wb.dat_i;
  assign cnt_nxt = cnt_q + CW'(push) - CW'(pop);
  assign room    = cnt_nxt < CW'(DEPTH);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    halted_d = halted_q;
    unique case (state_q)
      IDLE: begin
        if (!jump && !halted_q && room)
          state_d = REQ;
      end
      REQ: begin
        if (jump) begin
          state_d = resp ? IDLE : DROP;
        end else if (wb.ack_i) begin
          pc_d    = pc_q + XLEN'(4);
          state_d = room ? REQ : IDLE;
        end else if (wb.err_i) begin
          halted_d = 1'b1;
          state_d  = IDLE;
        end
      end
      DROP: begin
        if (resp)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (jump) begin
      pc_d     = tgt;
      halted_d = 1'b0;
    end
  end

  // Address only moves when a new request starts, so it is
  // stable for the whole cycle including a DROP.
  always_comb begin
    adr_d = adr_q;
    if (state_d == REQ)
      adr_d = pc_d;
  end

  always_comb begin
    cnt_d = cnt_nxt;
    rd_d  = rd_q + AW'(pop);
    wr_d  = wr_q + AW'(push);
    if (jump) begin
      cnt_d = '0;
      rd_d  = '0;
      wr_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      adr_q    <= RESET_PC;
      halted_q <= 1'b0;
      cnt_q    <= '0;
      rd_q     <= '0;
      wr_q     <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      adr_q    <= adr_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ir_mem[wr_q]  <= push_ir;
      pc_mem[wr_q]  <= pc_q;
      flt_mem[wr_q] <= wb.err_i;
    end
  end

  assign wb.cyc_o = (state_q != IDLE);
  assign wb.stb_o = wb.cyc_o;
  assign wb.we_o  = 1'b0;
  assign wb.sel_o = '1;
  assign wb.adr_o = adr_q;

  assign inst_valid = (cnt_q != '0);
  assign inst_ir    = ir_mem[rd_q];
  assign inst_pc    = pc_mem[rd_q];
  assign inst_fault = inst_valid & flt_mem[rd_q];
  assign busy       = wb.cyc_o | inst_valid;

endmodule

// File: tb/tb_fetch_prefetch_q.sv
// Directed bench for fetch_prefetch_q: one task per scenario,
// with a programmable wait-state / error Wishbone slave.
module tb_fetch_prefetch_q;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_ready = 1'b0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = '0;
  logic        inst_valid, inst_fault, busy;
  logic [31:0] inst_ir, inst_pc;

  logic        ready_w = 1'b1;
  logic        valid_w, fault_w, busy_w;
  logic [31:0] ir_w, pc_w;

  int n_chk = 0;
  int n_fail = 0;

  int          wait_n = 0;
  int          wcnt = 0;
  logic        err_en = 1'b0;
  logic [31:0] err_adr = '0;
  int          ack_cnt = 0;

  always #5 clk = ~clk;

  fetch_prefetch_q_if #(.XLEN(32)) bus ();
  fetch_prefetch_q_if #(.XLEN(32)) bus_w ();

  fetch_prefetch_q #(
    .XLEN(32), .DEPTH(4), .RESET_PC(32'h0000_0000)
  ) dut (
    .clk(clk), .rst(rst), .wb(bus),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_ir(inst_ir), .inst_pc(inst_pc),
    .inst_fault(inst_fault), .jump(jump),
    .jump_target(jump_target), .busy(busy)
  );

  fetch_prefetch_q #(
    .XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)
  ) dut_w (
    .clk(clk), .rst(rst), .wb(bus_w),
    .inst_valid(valid_w), .inst_ready(ready_w),
    .inst_ir(ir_w), .inst_pc(pc_w),
    .inst_fault(fault_w), .jump(1'b0),
    .jump_target(32'h0), .busy(busy_w)
  );

  assign bus_w.ack_i = bus_w.cyc_o;
  assign bus_w.err_i = 1'b0;
  assign bus_w.dat_i = bus_w.adr_o ^ 32'hFFFF_0000;

  // Slave: responds after wait_n idle cycles of cyc_o.
  always @(negedge clk) begin
    if (rst || !bus.cyc_o) begin
      bus.ack_i = 1'b0;
      bus.err_i = 1'b0;
      bus.dat_i = '0;
      wcnt = 0;
    end else begin
      if (bus.ack_i || bus.err_i)
        wcnt = 0;
      if (wcnt >= wait_n) begin
        if (err_en && bus.adr_o == err_adr) begin
          bus.ack_i = 1'b0;
          bus.err_i = 1'b1;
          bus.dat_i = '0;
        end else begin
          bus.ack_i = 1'b1;
          bus.err_i = 1'b0;
          bus.dat_i = bus.adr_o ^ 32'hFFFF_0000;
        end
      end else begin
        bus.ack_i = 1'b0;
        bus.err_i = 1'b0;
        wcnt = wcnt + 1;
      end
    end
  end

  always @(posedge clk)
    if (bus.cyc_o && bus.ack_i)
      ack_cnt <= ack_cnt + 1;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    jump = 1'b0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    n_chk++;
    if (bus.cyc_o !== 1'b0 || bus.stb_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_cyc got %b/%b want 0/0", bus.cyc_o, bus.stb_o);
    end
    n_chk++;
    if (bus.adr_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_adr got %h want 0", bus.adr_o);
    end
    n_chk++;
    if ({inst_valid, inst_fault, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 000",
               {inst_valid, inst_fault, busy});
    end
    n_chk++;
    if (bus.we_o !== 1'b0 || bus.sel_o !== 4'hF) begin
      n_fail++;
      $display("FAIL tie_we_sel got %b/%h want 0/f", bus.we_o, bus.sel_o);
    end
  endtask

  task automatic test_stream;
    wait_n = 0;
    inst_ready = 1'b1;
    do_reset;
    tick;
    n_chk++;
    if (inst_valid !== 1'b0 || bus.cyc_o !== 1'b1) begin
      n_fail++;
      $display("FAIL lat1 got v=%b cyc=%b want v=0 cyc=1",
               inst_valid, bus.cyc_o);
    end
    tick;
    for (int i = 0; i < 6; i++) begin
      n_chk++;
      if (inst_valid !== 1'b1 || bus.cyc_o !== 1'b1 ||
          inst_pc !== 32'(4 * i) ||
          inst_ir !== (32'(4 * i) ^ 32'hFFFF_0000) ||
          inst_fault !== 1'b0) begin
        n_fail++;
        $display("FAIL stream%0d got v=%b cyc=%b pc=%h ir=%h want pc=%h",
                 i, inst_valid, bus.cyc_o, inst_pc, inst_ir, 4 * i);
      end
      tick;
    end
  endtask

  task automatic test_full;
    int base;
    wait_n = 0;
    inst_ready = 1'b0;
    do_reset;
    base = ack_cnt;
    repeat (5) tick;
    n_chk++;
    if (bus.cyc_o !== 1'b0 || ack_cnt - base !== 4) begin
      n_fail++;
      $display("FAIL full_stop got cyc=%b acks=%0d want 0/4",
               bus.cyc_o, ack_cnt - base);
    end
    repeat (3) tick;
    n_chk++;
    if (bus.cyc_o !== 1'b0 || inst_valid !== 1'b1 || inst_pc !== 32'h0 ||
        ack_cnt - base !== 4) begin
      n_fail++;
      $display("FAIL full_hold got cyc=%b v=%b pc=%h acks=%0d",
               bus.cyc_o, inst_valid, inst_pc, ack_cnt - base);
    end
    inst_ready = 1'b1;
    tick;
    inst_ready = 1'b0;
    n_chk++;
    if (bus.cyc_o !== 1'b1 || bus.adr_o !== 32'h10 || inst_pc !== 32'h4) begin
      n_fail++;
      $display("FAIL full_refill got cyc=%b adr=%h pc=%h want 1/10/4",
               bus.cyc_o, bus.adr_o, inst_pc);
    end
    tick;
    tick;
    n_chk++;
    if (bus.cyc_o !== 1'b0 || ack_cnt - base !== 5) begin
      n_fail++;
      $display("FAIL full_one got cyc=%b acks=%0d want 0/5",
               bus.cyc_o, ack_cnt - base);
    end
  endtask

  task automatic test_jump_wait;
    bit seen;
    wait_n = 3;
    inst_ready = 1'b1;
    do_reset;
    tick;
    tick;
    jump = 1'b1;
    jump_target = 32'h0000_1002;
    tick;
    jump = 1'b0;
    n_chk++;
    if (bus.cyc_o !== 1'b1 || bus.adr_o !== 32'h0) begin
      n_fail++;
      $display("FAIL drop_hold got cyc=%b adr=%h want 1/0",
               bus.cyc_o, bus.adr_o);
    end
    tick;
    tick;
    n_chk++;
    if (bus.cyc_o !== 1'b0 || inst_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_end got cyc=%b v=%b want 0/0",
               bus.cyc_o, inst_valid);
    end
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick;
      if (inst_valid) begin
        n_chk++;
        n_fail++;
        $display("FAIL stale_head got pc=%h want none", inst_pc);
      end
      seen = bus.cyc_o;
    end
    n_chk++;
    if (!seen || bus.adr_o !== 32'h1000) begin
      n_fail++;
      $display("FAIL jump_adr got cyc=%b adr=%h want 1/1000",
               seen, bus.adr_o);
    end
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick;
      seen = inst_valid;
    end
    n_chk++;
    if (!seen || inst_pc !== 32'h1000 || inst_ir !== 32'hFFFF_1000) begin
      n_fail++;
      $display("FAIL jump_head got v=%b pc=%h ir=%h want 1/1000/ffff1000",
               seen, inst_pc, inst_ir);
    end
    wait_n = 0;
  endtask

  task automatic test_jump_ack;
    wait_n = 0;
    inst_ready = 1'b1;
    do_reset;
    repeat (4) tick;
    jump = 1'b1;
    jump_target = 32'h0000_0200;
    tick;
    jump = 1'b0;
    n_chk++;
    if (inst_valid !== 1'b0 || bus.cyc_o !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL jack_flush got v=%b cyc=%b busy=%b want 000",
               inst_valid, bus.cyc_o, busy);
    end
    tick;
    n_chk++;
    if (bus.cyc_o !== 1'b1 || bus.adr_o !== 32'h200) begin
      n_fail++;
      $display("FAIL jack_adr got cyc=%b adr=%h want 1/200",
               bus.cyc_o, bus.adr_o);
    end
    tick;
    n_chk++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h200) begin
      n_fail++;
      $display("FAIL jack_head got v=%b pc=%h want 1/200",
               inst_valid, inst_pc);
    end
  endtask

  task automatic test_err;
    wait_n = 0;
    err_en = 1'b1;
    err_adr = 32'h8;
    inst_ready = 1'b1;
    do_reset;
    repeat (4) tick;
    n_chk++;
    if (inst_valid !== 1'b1 || inst_fault !== 1'b1 ||
        inst_pc !== 32'h8 || inst_ir !== 32'h0 || bus.cyc_o !== 1'b0) begin
      n_fail++;
      $display("FAIL err_head got v=%b f=%b pc=%h ir=%h cyc=%b",
               inst_valid, inst_fault, inst_pc, inst_ir, bus.cyc_o);
    end
    repeat (5) tick;
    n_chk++;
    if (bus.cyc_o !== 1'b0 || busy !== 1'b0 || inst_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL err_halt got cyc=%b busy=%b v=%b want 000",
               bus.cyc_o, busy, inst_valid);
    end
    jump = 1'b1;
    jump_target = 32'h40;
    tick;
    jump = 1'b0;
    err_en = 1'b0;
    tick;
    n_chk++;
    if (bus.cyc_o !== 1'b1 || bus.adr_o !== 32'h40) begin
      n_fail++;
      $display("FAIL err_resume got cyc=%b adr=%h want 1/40",
               bus.cyc_o, bus.adr_o);
    end
    tick;
    n_chk++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h40 || inst_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL err_new got v=%b pc=%h f=%b want 1/40/0",
               inst_valid, inst_pc, inst_fault);
    end
  endtask

  task automatic test_wrap;
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'hFFFF_FFF8;
    exp_pc[1] = 32'hFFFF_FFFC;
    exp_pc[2] = 32'h0000_0000;
    do_reset;
    tick;
    for (int i = 0; i < 3; i++) begin
      tick;
      n_chk++;
      if (valid_w !== 1'b1 || pc_w !== exp_pc[i] ||
          ir_w !== (exp_pc[i] ^ 32'hFFFF_0000) || fault_w !== 1'b0) begin
        n_fail++;
        $display("FAIL wrap%0d got v=%b pc=%h ir=%h want pc=%h",
                 i, valid_w, pc_w, ir_w, exp_pc[i]);
      end
    end
    n_chk++;
    if (bus_w.stb_o !== bus_w.cyc_o || bus_w.we_o !== 1'b0 ||
        bus_w.sel_o !== 4'hF || busy_w !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_bus got stb=%b cyc=%b we=%b sel=%h busy=%b",
               bus_w.stb_o, bus_w.cyc_o, bus_w.we_o, bus_w.sel_o, busy_w);
    end
  endtask

  task automatic test_async_reset;
    wait_n = 3;
    inst_ready = 1'b1;
    do_reset;
    tick;
    #2;
    rst = 1'b1;
    #1;
    n_chk++;
    if (bus.cyc_o !== 1'b0 || busy !== 1'b0 || bus.adr_o !== 32'h0) begin
      n_fail++;
      $display("FAIL arst_drop got cyc=%b busy=%b adr=%h want 0/0/0",
               bus.cyc_o, busy, bus.adr_o);
    end
    tick;
    rst = 1'b0;
    tick;
    n_chk++;
    if (bus.cyc_o !== 1'b1 || bus.adr_o !== 32'h0 || inst_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_restart got cyc=%b adr=%h v=%b want 1/0/0",
               bus.cyc_o, bus.adr_o, inst_valid);
    end
    wait_n = 0;
  endtask

  initial begin
    test_reset;
    test_stream;
    test_full;
    test_jump_wait;
    test_jump_ack;
    test_err;
    test_wrap;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
